// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: two-port arbiter in front of a single combinational
// instruction ROM. Requester 0 is the IF stage, requester 1 is the
// debug/loader read port.
//
// Handshake: a requester raises mN_req with a stable mN_addr and holds both
// until mN_gnt pulses. The address is accepted in the gnt cycle. The word
// returns on mN_rdata with a one-cycle mN_rvalid pulse two cycles later.
// There is no back-pressure on the response side. A granted access always
// completes unless reset intervenes.
//
// Optional feature: define IFARB_ROUND_ROBIN_EN to resolve simultaneous
// requests round-robin. Otherwise requester 0 always wins ties.
module inst_rom_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  r_state;
  logic [29:0] r_addr;     // word address of the access in flight
  logic        r_owner;    // 0 = requester 0, 1 = requester 1
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;
  logic        w_arb_open;
  logic        w_pick1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_unused_lsbs;

  // Byte-offset bits are dropped because the ROM is word-addressed.
  assign w_unused_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

`ifdef IFARB_ROUND_ROBIN_EN
  logic r_last_m1;  // 1 when requester 1 received the most recent grant

  // On a tie, grant the requester that did not win last time.
  always_comb begin
    w_pick1 = m1_req && (!m0_req || !r_last_m1);
  end

  // Update the last-grant pointer on every grant. Reset points it at
  // requester 1, so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_m1 <= 1'b1;
    end else if (w_gnt0 || w_gnt1) begin
      r_last_m1 <= w_gnt1;
    end
  end
`else
  // Fixed priority: requester 1 wins only when requester 0 is not asking.
  always_comb begin
    w_pick1 = m1_req && !m0_req;
  end
`endif

  // Grants are combinational and are only offered while no ROM read is in progress.
  always_comb begin
    w_arb_open = !rst && ((r_state == IDLE) || (r_state == RESP));
    w_gnt1     = w_arb_open && w_pick1;
    w_gnt0     = w_arb_open && m0_req && !w_pick1;
  end

  // Drive the ROM only during READ. Responses are given only during RESP.
  always_comb begin
    m0_gnt    = w_gnt0;
    m1_gnt    = w_gnt1;
    rom_ce    = !rst && (r_state == READ);
    rom_addr  = rom_ce ? {r_addr, 2'b00} : 32'd0;
    m0_rvalid = !rst && (r_state == RESP) && !r_owner;
    m1_rvalid = !rst && (r_state == RESP) && r_owner;
    m0_rdata  = r_m0_rdata;
    m1_rdata  = r_m1_rdata;
    dbg_state = r_state;
  end

  // FSM, address/owner latch and per-owner read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= 30'd0;
      r_owner    <= 1'b0;
      r_m0_rdata <= 32'd0;
      r_m1_rdata <= 32'd0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_addr  <= w_gnt1 ? m1_addr[31:2] : m0_addr[31:2];
        r_owner <= w_gnt1;
      end
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) r_state <= READ;
        end
        READ: begin
          if (r_owner) r_m1_rdata <= rom_inst;
          else         r_m0_rdata <= rom_inst;
          r_state <= RESP;
        end
        RESP: begin
          r_state <= (w_gnt0 || w_gnt1) ? READ : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed testbench for inst_rom_arbiter. It follows the
// IFARB_ROUND_ROBIN_EN macro so that tie expectations match the build.
module tb_inst_rom_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  inst_rom_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word n = 0xC0DE_0000 + 7n + 1. The ROM returns garbage
  // when it is not enabled.
  function automatic logic [31:0] rom_word(input logic [29:0] idx);
    return 32'hC0DE_0000 + idx * 32'd7 + 32'd1;
  endfunction

  assign rom_inst = rom_ce ? rom_word(rom_addr[31:2]) : 32'hDEAD_BEEF;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; m0_req = 1'b1; m0_addr = 32'h4; m1_req = 1'b1; m1_addr = 32'h8;
    tick(); tick();
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rom_ce} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rom_ce});
    end
    checks++;
    if ({rom_addr, m0_rdata, m1_rdata} !== 96'd0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_data rom_addr=%h m0_rdata=%h m1_rdata=%h state=%0d exp all 0",
               rom_addr, m0_rdata, m1_rdata, dbg_state);
    end
    tick();
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_single();
    tick();
    m0_req = 1'b1; m0_addr = 32'h0000_0008;
    #1;
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      failures++;
      $display("FAIL single_gnt got m0=%b m1=%b exp m0=1 m1=0", m0_gnt, m1_gnt);
    end
    tick();
    m0_req = 1'b0;
    #1;
    checks++;
    if (rom_ce !== 1'b1 || rom_addr !== 32'h8 || m0_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_read got ce=%b addr=%h rvalid=%b exp ce=1 addr=00000008 rvalid=0",
               rom_ce, rom_addr, m0_rvalid);
    end
    tick();
    #1;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hC0DE_000F || m1_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_resp got rvalid=%b rdata=%h m1_rvalid=%b exp 1 c0de000f 0",
               m0_rvalid, m0_rdata, m1_rvalid);
    end
    checks++;
    if (rom_ce !== 1'b0 || rom_addr !== 32'd0) begin
      failures++;
      $display("FAIL single_rom_idle got ce=%b addr=%h exp 0 0", rom_ce, rom_addr);
    end
    tick();
    #1;
    checks++;
    if (m0_rvalid !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL single_after got rvalid=%b state=%0d exp 0 0", m0_rvalid, dbg_state);
    end
  endtask

  task automatic test_unaligned();
    m1_req = 1'b1; m1_addr = 32'h0000_0013;
    #1;
    checks++;
    if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
      failures++;
      $display("FAIL unal_gnt got m1=%b m0=%b exp 1 0", m1_gnt, m0_gnt);
    end
    tick();
    m1_req = 1'b0;
    #1;
    checks++;
    if (rom_ce !== 1'b1 || rom_addr !== 32'h0000_0010) begin
      failures++;
      $display("FAIL unal_addr got ce=%b addr=%h exp 1 00000010", rom_ce, rom_addr);
    end
    tick();
    #1;
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hC0DE_001D) begin
      failures++;
      $display("FAIL unal_resp got rvalid=%b rdata=%h exp 1 c0de001d", m1_rvalid, m1_rdata);
    end
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hC0DE_000F) begin
      failures++;
      $display("FAIL unal_m0_hold got rvalid=%b rdata=%h exp 0 c0de000f", m0_rvalid, m0_rdata);
    end
    tick();
  endtask

  task automatic test_tie();
    logic [1:0] exp_gnt [6];
    logic       second_m1;
`ifdef IFARB_ROUND_ROBIN_EN
    second_m1 = 1'b1;
`else
    second_m1 = 1'b0;
`endif
    // {m1_gnt, m0_gnt} per cycle.
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b00;
    exp_gnt[2] = second_m1 ? 2'b10 : 2'b01; exp_gnt[3] = 2'b00;
    exp_gnt[4] = 2'b01; exp_gnt[5] = 2'b00;
    m0_req = 1'b1; m0_addr = 32'h0000_0020;
    m1_req = 1'b1; m1_addr = 32'h0000_0044;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if ({m1_gnt, m0_gnt} !== exp_gnt[c]) begin
        failures++;
        $display("FAIL tie_gnt cycle=%0d got=%b exp=%b", c, {m1_gnt, m0_gnt}, exp_gnt[c]);
      end
      if (c == 2) begin
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hC0DE_0039) begin
          failures++;
          $display("FAIL tie_resp0 got rvalid=%b rdata=%h exp 1 c0de0039", m0_rvalid, m0_rdata);
        end
      end
      if (c == 4) begin
        checks++;
        if (second_m1 ? (m1_rvalid !== 1'b1 || m1_rdata !== 32'hC0DE_0078)
                      : (m0_rvalid !== 1'b1 || m0_rdata !== 32'hC0DE_0039 || m1_rvalid !== 1'b0)) begin
          failures++;
          $display("FAIL tie_resp1 got m0v=%b m0d=%h m1v=%b m1d=%h rr=%b",
                   m0_rvalid, m0_rdata, m1_rvalid, m1_rdata, second_m1);
        end
      end
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    #1;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      failures++;
      $display("FAIL tie_last got rvalid=%b gnt=%b%b exp 1 00", m0_rvalid, m1_gnt, m0_gnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exp_q [$];
    logic [31:0] e;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h30; addrs[3] = 32'h7C;
    for (int i = 0; i < 4; i++) begin
      m0_req = 1'b1; m0_addr = addrs[i];
      #1;
      checks++;
      if (m0_gnt !== 1'b1) begin
        failures++;
        $display("FAIL b2b_gnt idx=%0d got=%b exp=1", i, m0_gnt);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== e) begin
          failures++;
          $display("FAIL b2b_resp idx=%0d got rvalid=%b rdata=%h exp 1 %h", i, m0_rvalid, m0_rdata, e);
        end
      end
      exp_q.push_back(rom_word(addrs[i][31:2]));
      tick();
      #1;
      checks++;
      if (m0_gnt !== 1'b0 || rom_ce !== 1'b1 || rom_addr !== addrs[i] || m0_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_read idx=%0d got gnt=%b ce=%b addr=%h rvalid=%b exp 0 1 %h 0",
                 i, m0_gnt, rom_ce, rom_addr, m0_rvalid, addrs[i]);
      end
      tick();
    end
    m0_req = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== e || m0_gnt !== 1'b0) begin
      failures++;
      $display("FAIL b2b_last got rvalid=%b rdata=%h gnt=%b exp 1 %h 0", m0_rvalid, m0_rdata, m0_gnt, e);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    m1_req = 1'b1; m1_addr = 32'h0000_0008;
    #1;
    checks++;
    if (m1_gnt !== 1'b1) begin
      failures++;
      $display("FAIL abort_gnt got=%b exp=1", m1_gnt);
    end
    tick();
    m1_req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rom_ce} !== 5'b0 ||
        {rom_addr, m0_rdata, m1_rdata} !== 96'd0) begin
      failures++;
      $display("FAIL abort_clear got ctrl=%b addr=%h m0d=%h m1d=%h exp all 0",
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rom_ce}, rom_addr, m0_rdata, m1_rdata);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      checks++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || rom_ce !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet cycle=%0d got m0v=%b m1v=%b ce=%b exp 0 0 0",
                 c, m0_rvalid, m1_rvalid, rom_ce);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    m0_req = 1'b0; m0_addr = 32'd0;
    m1_req = 1'b0; m1_addr = 32'd0;
    test_reset();
    test_single();
    test_unaligned();
    test_tie();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_rom_arbiter.md
INST_ROM_ARBITER -- requirements
Module: inst_rom_arbiter

Interface
- REQ-001: No parameters; all address and data widths are 32 bits (RegBus/InstBus from defines.v).
- REQ-002: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003: rst  input  1  synchronous, active-high reset (RstEnable = 1'b1), sampled on rising clk.
- REQ-004: m0_req  input  1  requester 0 (IF stage) read request; held high until granted.
- REQ-005: m0_addr  input  32  requester 0 byte address; must be stable while m0_req is high.
- REQ-006: m0_gnt  output  1  one-cycle pulse; m0_addr is accepted this cycle.
- REQ-007: m0_rvalid  output  1  one-cycle pulse; m0_rdata holds the fetched word.
- REQ-008: m0_rdata  output  32  registered instruction word for requester 0.
- REQ-009: m1_req / m1_addr / m1_gnt / m1_rvalid / m1_rdata  same directions, widths and meanings as m0_*, for requester 1 (debug/loader read port).
- REQ-010: rom_ce  output  1  instruction ROM chip enable (ChipEnable = 1'b1).
- REQ-011: rom_addr  output  32  ROM byte address, with bits [1:0] forced to 0.
- REQ-012: rom_inst  input  32  combinational ROM read data, valid in the same cycle as rom_ce/rom_addr.

Function
- REQ-013: The FSM SHALL have exactly three states: IDLE, READ and RESP.
- REQ-014: Grant is issued combinationally only in IDLE or RESP, and only when at least one request is high. At most one of m0_gnt/m1_gnt SHALL be high in any cycle.
- REQ-015: On grant, the block SHALL latch the winner's address and owner ID, then go to READ.
- REQ-016: READ lasts exactly one cycle. In READ, rom_ce = 1 and rom_addr = {latched_addr[31:2], 2'b00}. rom_inst is captured at the end of READ into the owner's rdata register. The FSM then goes to RESP.
- REQ-017: In RESP, the owner's rvalid SHALL be high for exactly one cycle. The next state is READ if a new grant is issued in that same cycle, otherwise IDLE.
- REQ-018: Latency: gnt in cycle T, rvalid in cycle T+2. Sustained throughput is one word every 2 cycles.
- REQ-019: Outside READ, rom_ce SHALL be 0 and rom_addr SHALL be 0.
- REQ-020: A non-owner's rdata SHALL hold its previous value. A non-owner's rvalid SHALL be 0.
- REQ-021: Priority when both requests are high is selected by the Configuration section (REQ-026/027). A single requester always wins.
- REQ-022: A request dropped before grant is ignored; no access is generated for it.
- REQ-023: Once granted, an access always completes with rvalid, even if the requester's req falls.

Reset
- REQ-024: While rst = 1, the block SHALL set: state = IDLE; all gnt, rvalid, rdata, rom_ce and rom_addr = 0; last-grant pointer = requester 1; no grant issued.
- REQ-025: Reset asserted in READ or RESP SHALL abort the access. No rvalid for that access SHALL appear after reset deasserts.

Configuration
- REQ-026: When macro IFARB_ROUND_ROBIN_EN is defined, simultaneous requests are granted to the requester not granted most recently. The last-grant pointer is updated on every grant, and requester 0 wins the first tie after reset.
- REQ-027: When IFARB_ROUND_ROBIN_EN is undefined, requester 0 SHALL always win ties (fixed priority), and the last-grant pointer is unused.

Verification
- REQ-028: Single read: m0_req=1, m0_addr=0x0000_0008 at T -> m0_gnt at T; rom_ce=1 and rom_addr=0x8 at T+1; m0_rvalid=1 with m0_rdata=ROM word 2 at T+2.
- REQ-029: Unaligned address: m1_addr=0x0000_0013 -> rom_addr=0x0000_0010; m1_rdata=ROM word 4; m0 outputs unchanged.
- REQ-030: Both requesters held high for 6 cycles, round-robin build -> grants m0, m1, m0 at T, T+2, T+4; fixed-priority build -> grants m0 at T, T+2, T+4 and never m1.
- REQ-031: Back-to-back: m0_req held high with the address changed after each gnt -> gnt every 2 cycles; rvalid every 2 cycles with data matching each address.
- REQ-032: rst=1 during READ -> next cycle all outputs are 0; after release, no rvalid appears until a new grant.
